hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage RV32I core. It replaces the always-enabled, flush-only pipeline-register control in the core top level, adding:
- E-stage operand forwarding
- load-use interlock
- a variable-latency data-memory wait handshake with timeout
- saturating stall/flush performance counters

The top level wires its outputs to the `en`/`clr` pins of the F/D, D/E, E/M and M/W `pipereg` banks and to the E-stage operand muxes.

## Interface
Parameters:
- REG_ADDR_W, 5, register-file address width
- FWD_EN, 1, 1 = forwarding mode; 0 = interlock-only mode (RAW resolved purely by stalling)
- MAX_MEM_WAIT, 15, consecutive memory-wait cycles before timeout error
- COUNT_W, 16, performance counter width

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- Rs1D_i, Rs2D_i  in  REG_ADDR_W  source registers of the instruction in D
- Rs1E_i, Rs2E_i  in  REG_ADDR_W  source registers of the instruction in E
- RdE_i, RdM_i, RdW_i  in  REG_ADDR_W  destination registers in E/M/W
- RegWriteE_i, RegWriteM_i, RegWriteW_i  in  1  register-write enables per stage
- ResultSrcE_i  in  2  2'b01 = load in E
- PCSrcE_i  in  1  branch/jump taken in E
- MemReqM_i  in  1  load/store active in M
- MemAckM_i  in  1  data memory completes access this cycle
- StallF_o, StallD_o, StallE_o, StallM_o  out  1  hold the corresponding pipeline register (en = ~Stall)
- FlushD_o, FlushE_o, FlushW_o  out  1  clear the corresponding pipeline register to a bubble
- ForwardAE_o, ForwardBE_o  out  2  00 = RD1E/RD2E; 10 = ALUResultM; 01 = ResultW
- MemErr_o  out  1  sticky memory-timeout flag
- StallCnt_o, FlushCnt_o  out  COUNT_W  saturating event counters

## Operation
Let x0 denote a zero register address. A stage "hits" rs when all hold: RegWrite of that stage = 1, its Rd ≠ x0, and its Rd equals rs.

Forwarding (FWD_EN = 1, combinational):
- ForwardAE = 10 if M hits Rs1E; else 01 if W hits Rs1E; else 00. ForwardBE is the same with Rs2E.
- M has priority over W.
- When FWD_EN = 0, both forwarding outputs are tied to 00.

Load-use stall:
- Condition: FWD_EN = 1, ResultSrcE = 01, RdE ≠ x0, and RdE equals Rs1D or Rs2D.
- Response: StallF = StallD = 1 and FlushE = 1.

Interlock stall (FWD_EN = 0):
- Condition: E, M or W hits Rs1D or Rs2D.
- Response: StallF, StallD and FlushE asserted.

Branch flush:
- PCSrcE = 1 gives FlushD = FlushE = 1.
- It overrides load-use and interlock stalls: StallF/StallD are forced to 0 so the redirect is taken.

Memory wait:
- memstall = MemReqM & ~MemAckM.
- Response: StallF, StallD, StallE and StallM are all asserted, and FlushW = 1 (bubble into W).
- memstall overrides every other condition. While it holds, FlushD/FlushE = 0 even if PCSrcE = 1; the branch in E is held and re-asserts when the wait ends.

Memory FSM (registered):
- IDLE → WAIT when memstall.
- WAIT → IDLE when MemAckM.
- WAIT → ERR when the wait counter reaches MAX_MEM_WAIT.
- ERR is absorbing until reset. In ERR: MemErr_o = 1, all stalls are asserted, and FlushW = 1.
- The wait counter is cleared in IDLE and increments each cycle in WAIT.

Counters:
- StallCnt increments on any cycle with StallF = 1.
- FlushCnt increments on any cycle with FlushE = 1 caused by PCSrcE.
- Both saturate at all-ones.

## Timing
- Forward, stall and flush outputs are combinational from inputs and the current FSM state, with zero-cycle latency.
- The wait counter, FSM state, MemErr and the performance counters are registered.
- Reset (rst = 0, asynchronous) puts the FSM in IDLE and clears the wait counter, MemErr_o, StallCnt_o and FlushCnt_o to 0.
- Assuming quiescent inputs at reset, all stall/flush outputs read 0 and both forwarding outputs read 00.
- Timeout: with MemReqM held and no ack, the cycle-1 request enters WAIT. MemErr_o rises on the clock edge at which the counter equals MAX_MEM_WAIT, i.e. MAX_MEM_WAIT + 1 stalled cycles after the request.
- An ack arriving in the same cycle as the timeout threshold wins: the FSM goes to IDLE and no error is raised.
- Reset asserted mid-WAIT or in ERR returns the FSM to IDLE immediately.

## Structure
- Shared package `hazard_pkg` holds:
  - the forward-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10
  - the ResultSrc load encoding RES_LOAD = 2'b01
  - the FSM enum mem_state_t {IDLE, WAIT, ERR}
- One sub-module, `sat_counter` (parametrised on COUNT_W, with increment enable), is instantiated twice for the two performance counters.

## Test plan
1. Forwarding priority: `add x5` in M and `add x5` in W both writing x5, with Rs1E = 5 → ForwardAE = 10. Then with RdM = 0 → ForwardAE = 01.
2. Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 → StallF = StallD = FlushE = 1 for exactly one cycle. The next cycle has no stall and ForwardBE = 01 once the load reaches W.
3. Branch vs load-use in the same cycle: PCSrcE = 1 plus a load-use hit → FlushD = FlushE = 1, StallF = StallD = 0, and FlushCnt increments by 1.
4. Memory wait: MemReqM = 1 with ack after 3 cycles → StallF/StallD/StallE/StallM = 1 and FlushW = 1 for 3 cycles, then the FSM returns to IDLE and StallCnt = 3.
5. Timeout with MAX_MEM_WAIT = 4 and no ack: MemErr_o = 1 after 5 stalled cycles and stays set. Asserting rst = 0 then clears MemErr_o, the FSM and the counters asynchronously.
6. FWD_EN = 0: RegWriteM = 1, RdM = 3, Rs1D = 3 → StallF = StallD = FlushE = 1 and ForwardAE = 00. Also rd = x0 in every stage → no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects,
// the load ResultSrc code and the data-memory wait FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use and
// interlock stalls, branch flush, data-memory wait/timeout and event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter bit FWD_EN       = 1'b1,
  parameter int MAX_MEM_WAIT = 15,
  parameter int COUNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D_i,
  input  logic [REG_ADDR_W-1:0] Rs2D_i,
  input  logic [REG_ADDR_W-1:0] Rs1E_i,
  input  logic [REG_ADDR_W-1:0] Rs2E_i,
  input  logic [REG_ADDR_W-1:0] RdE_i,
  input  logic [REG_ADDR_W-1:0] RdM_i,
  input  logic [REG_ADDR_W-1:0] RdW_i,
  input  logic                  RegWriteE_i,
  input  logic                  RegWriteM_i,
  input  logic                  RegWriteW_i,
  input  logic [1:0]            ResultSrcE_i,
  input  logic                  PCSrcE_i,
  input  logic                  MemReqM_i,
  input  logic                  MemAckM_i,
  output logic                  StallF_o,
  output logic                  StallD_o,
  output logic                  StallE_o,
  output logic                  StallM_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o,
  output logic                  FlushW_o,
  output logic [1:0]            ForwardAE_o,
  output logic [1:0]            ForwardBE_o,
  output logic                  MemErr_o,
  output logic [COUNT_W-1:0]    StallCnt_o,
  output logic [COUNT_W-1:0]    FlushCnt_o
);

  localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1) + 1;

  function automatic logic hits(input logic we,
                                input logic [REG_ADDR_W-1:0] rd,
                                input logic [REG_ADDR_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  mem_state_t        stateReg;
  logic [WAIT_W-1:0] waitCnt;
  logic              memErrReg;
  logic              memStall, holdAll, loadUse, interlock, rawStall, flushInc;

  assign memStall = MemReqM_i & ~MemAckM_i;
  assign holdAll  = memStall | (stateReg == ERR);

  generate
    if (FWD_EN) begin : gFwd
      always_comb begin
        ForwardAE_o = FWD_RF;
        ForwardBE_o = FWD_RF;
        if (hits(RegWriteM_i, RdM_i, Rs1E_i))      ForwardAE_o = FWD_M;
        else if (hits(RegWriteW_i, RdW_i, Rs1E_i)) ForwardAE_o = FWD_W;
        if (hits(RegWriteM_i, RdM_i, Rs2E_i))      ForwardBE_o = FWD_M;
        else if (hits(RegWriteW_i, RdW_i, Rs2E_i)) ForwardBE_o = FWD_W;
      end
    end else begin : gNoFwd
      assign ForwardAE_o = FWD_RF;
      assign ForwardBE_o = FWD_RF;
    end
  endgenerate

  assign loadUse = FWD_EN && (ResultSrcE_i == RES_LOAD) && (RdE_i != '0) &&
                   ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  assign interlock = !FWD_EN && (
    hits(RegWriteE_i, RdE_i, Rs1D_i) || hits(RegWriteE_i, RdE_i, Rs2D_i) ||
    hits(RegWriteM_i, RdM_i, Rs1D_i) || hits(RegWriteM_i, RdM_i, Rs2D_i) ||
    hits(RegWriteW_i, RdW_i, Rs1D_i) || hits(RegWriteW_i, RdW_i, Rs2D_i));

  assign rawStall = loadUse | interlock;

  // A memory wait (or timeout) freezes everything, so a taken branch in E is
  // simply held and redirects once the wait clears.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (holdAll) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else begin
      StallF_o = rawStall & ~PCSrcE_i;
      StallD_o = rawStall & ~PCSrcE_i;
      FlushD_o = PCSrcE_i;
      FlushE_o = PCSrcE_i | rawStall;
    end
  end

  // Timeout fires on the edge where the count reaches MAX_MEM_WAIT; an ack in
  // that same cycle takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg  <= IDLE;
      waitCnt   <= '0;
      memErrReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          waitCnt <= '0;
          if (memStall) stateReg <= WAIT;
        end
        WAIT: begin
          if (MemAckM_i) begin
            stateReg <= IDLE;
            waitCnt  <= '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
            if ((waitCnt + 1'b1) == WAIT_W'(MAX_MEM_WAIT)) begin
              stateReg  <= ERR;
              memErrReg <= 1'b1;
            end
          end
        end
        default: begin
          stateReg  <= ERR;
          memErrReg <= 1'b1;
        end
      endcase
    end
  end

  assign MemErr_o = memErrReg;
  assign flushInc = FlushE_o & PCSrcE_i;

  sat_counter #(.COUNT_W(COUNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallF_o),
    .count (StallCnt_o)
  );

  sat_counter #(.COUNT_W(COUNT_W)) uFlushCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flushInc),
    .count (FlushCnt_o)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a forwarding instance (MAX_MEM_WAIT = 4)
// and an interlock-only instance driven from the same stimulus.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regWriteE, regWriteM, regWriteW, pcSrcE, memReqM, memAckM;
  logic [1:0] resultSrcE;

  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
  logic [1:0] fwdA, fwdB;
  logic [CW-1:0] stallCnt, flushCnt;

  logic ilStallF, ilStallD, ilStallE, ilStallM, ilFlushD, ilFlushE, ilFlushW, ilMemErr;
  logic [1:0] ilFwdA, ilFwdB;
  logic [CW-1:0] ilStallCnt, ilFlushCnt;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(AW), .FWD_EN(1'b1), .MAX_MEM_WAIT(4), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D_i(rs1D), .Rs2D_i(rs2D), .Rs1E_i(rs1E), .Rs2E_i(rs2E),
    .RdE_i(rdE), .RdM_i(rdM), .RdW_i(rdW),
    .RegWriteE_i(regWriteE), .RegWriteM_i(regWriteM), .RegWriteW_i(regWriteW),
    .ResultSrcE_i(resultSrcE), .PCSrcE_i(pcSrcE), .MemReqM_i(memReqM), .MemAckM_i(memAckM),
    .StallF_o(stallF), .StallD_o(stallD), .StallE_o(stallE), .StallM_o(stallM),
    .FlushD_o(flushD), .FlushE_o(flushE), .FlushW_o(flushW),
    .ForwardAE_o(fwdA), .ForwardBE_o(fwdB), .MemErr_o(memErr),
    .StallCnt_o(stallCnt), .FlushCnt_o(flushCnt)
  );

  hazard_unit #(.REG_ADDR_W(AW), .FWD_EN(1'b0), .MAX_MEM_WAIT(4), .COUNT_W(CW)) dutIl (
    .clk(clk), .rst(rst),
    .Rs1D_i(rs1D), .Rs2D_i(rs2D), .Rs1E_i(rs1E), .Rs2E_i(rs2E),
    .RdE_i(rdE), .RdM_i(rdM), .RdW_i(rdW),
    .RegWriteE_i(regWriteE), .RegWriteM_i(regWriteM), .RegWriteW_i(regWriteW),
    .ResultSrcE_i(resultSrcE), .PCSrcE_i(pcSrcE), .MemReqM_i(memReqM), .MemAckM_i(memAckM),
    .StallF_o(ilStallF), .StallD_o(ilStallD), .StallE_o(ilStallE), .StallM_o(ilStallM),
    .FlushD_o(ilFlushD), .FlushE_o(ilFlushE), .FlushW_o(ilFlushW),
    .ForwardAE_o(ilFwdA), .ForwardBE_o(ilFwdB), .MemErr_o(ilMemErr),
    .StallCnt_o(ilStallCnt), .FlushCnt_o(ilFlushCnt)
  );

  typedef struct {
    string         tag;
    logic [3:0]    stall;   // {F,D,E,M}
    logic [2:0]    flush;   // {D,E,W}
    logic [1:0]    fwdA;
    logic [1:0]    fwdB;
    logic          memErr;
    logic [CW-1:0] sCnt;
    logic [CW-1:0] fCnt;
    logic          chkIl;
    logic          ilStall;
    logic          ilFlushE;
    logic [1:0]    ilFwdA;
  } exp_t;

  exp_t expQ[$];
  exp_t mon;
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] expS = '0;
  logic [CW-1:0] expF = '0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
    rdE = '0; rdM = '0; rdW = '0;
    regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
    resultSrcE = 2'b00; pcSrcE = 1'b0; memReqM = 1'b0; memAckM = 1'b0;
  endtask

  // Queue this cycle's expectation, advance the running counter totals the
  // DUT should show from the next cycle on, then move to the next cycle.
  task automatic step(input string tag, input logic [3:0] st, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic me,
                      input logic chk, input logic ilS, input logic ilF, input logic [1:0] ilA);
    exp_t e;
    e.tag = tag; e.stall = st; e.flush = fl; e.fwdA = fa; e.fwdB = fb; e.memErr = me;
    e.sCnt = expS; e.fCnt = expF;
    e.chkIl = chk; e.ilStall = ilS; e.ilFlushE = ilF; e.ilFwdA = ilA;
    expQ.push_back(e);
    if (rst) begin
      if (st[3] && (expS != '1)) expS = expS + 1'b1;
      if (fl[1] && pcSrcE && (expF != '1)) expF = expF + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      mon = expQ.pop_front();
      checkVal({mon.tag, ".stall"}, 32'({stallF, stallD, stallE, stallM}), 32'(mon.stall));
      checkVal({mon.tag, ".flush"}, 32'({flushD, flushE, flushW}), 32'(mon.flush));
      checkVal({mon.tag, ".fwdA"}, 32'(fwdA), 32'(mon.fwdA));
      checkVal({mon.tag, ".fwdB"}, 32'(fwdB), 32'(mon.fwdB));
      checkVal({mon.tag, ".memErr"}, 32'(memErr), 32'(mon.memErr));
      checkVal({mon.tag, ".stallCnt"}, 32'(stallCnt), 32'(mon.sCnt));
      checkVal({mon.tag, ".flushCnt"}, 32'(flushCnt), 32'(mon.fCnt));
      if (mon.chkIl) begin
        checkVal({mon.tag, ".ilStallF"}, 32'(ilStallF), 32'(mon.ilStall));
        checkVal({mon.tag, ".ilStallD"}, 32'(ilStallD), 32'(mon.ilStall));
        checkVal({mon.tag, ".ilFlushE"}, 32'(ilFlushE), 32'(mon.ilFlushE));
        checkVal({mon.tag, ".ilFwdA"}, 32'(ilFwdA), 32'(mon.ilFwdA));
      end
      $display("txn %-10s stall=%b%b%b%b flush=%b%b%b fwd=%b/%b err=%b cnt=%0d/%0d",
               mon.tag, stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               fwdA, fwdB, memErr, stallCnt, flushCnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clearIn();
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);
    rst = 1'b1;

    // Forwarding priority and write-enable gating
    rs1E = 5; regWriteM = 1'b1; rdM = 5; regWriteW = 1'b1; rdW = 5;
    step("fwdMpri", 4'b0000, 3'b000, FWD_M, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);
    rdM = 0;
    step("fwdW", 4'b0000, 3'b000, FWD_W, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);
    rdM = 5; regWriteM = 1'b0; rs2E = 5;
    step("fwdWeM", 4'b0000, 3'b000, FWD_W, FWD_W, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);

    // Load-use: one stall, bubble, then forward from W
    clearIn();
    resultSrcE = RES_LOAD; regWriteE = 1'b1; rdE = 7; rs2D = 7;
    step("loadUse", 4'b1100, 3'b010, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b1, 1'b1, FWD_RF);
    clearIn();
    rs2D = 7; regWriteM = 1'b1; rdM = 7;
    step("luBubble", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b0, 1'b0, 1'b0, FWD_RF);
    clearIn();
    rs2E = 7; regWriteW = 1'b1; rdW = 7;
    step("luFwdW", 4'b0000, 3'b000, FWD_RF, FWD_W, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);

    // Branch overrides a simultaneous load-use stall
    clearIn();
    resultSrcE = RES_LOAD; regWriteE = 1'b1; rdE = 7; rs2D = 7; pcSrcE = 1'b1;
    step("brOverLU", 4'b0000, 3'b110, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b1, FWD_RF);
    clearIn();
    step("idle1", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);

    // Memory wait of 3 cycles; the branch in E is held during the wait
    memReqM = 1'b1;
    step("memW1", 4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b1, 1'b0, FWD_RF);
    pcSrcE = 1'b1;
    step("memW2br", 4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b1, 1'b0, FWD_RF);
    pcSrcE = 1'b0;
    step("memW3", 4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b1, 1'b0, FWD_RF);
    memAckM = 1'b1;
    step("memAck", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);
    clearIn();
    pcSrcE = 1'b1;
    step("brAfter", 4'b0000, 3'b110, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b1, FWD_RF);
    clearIn();
    step("idle2", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);

    // Timeout: error appears after the fifth stalled cycle and is sticky
    memReqM = 1'b1;
    for (int i = 1; i <= 5; i++)
      step($sformatf("to%0d", i), 4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b0, 1'b0, 1'b0, 1'b0, FWD_RF);
    memReqM = 1'b0;
    step("errHold", 4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b1, 1'b0, 1'b0, 1'b0, FWD_RF);
    pcSrcE = 1'b1;
    step("errBr", 4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b1, 1'b0, 1'b0, 1'b0, FWD_RF);
    pcSrcE = 1'b0;

    // Asynchronous reset in the middle of a cycle
    #2;
    rst = 1'b0;
    #1;
    checkVal("rstMemErr", 32'(memErr), 32'd0);
    checkVal("rstStallCnt", 32'(stallCnt), 32'd0);
    checkVal("rstFlushCnt", 32'(flushCnt), 32'd0);
    checkVal("rstStallF", 32'(stallF), 32'd0);
    checkVal("rstFlushW", 32'(flushW), 32'd0);
    expS = '0;
    expF = '0;
    @(posedge clk);
    #1;
    step("rstHold", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);
    rst = 1'b1;

    // Ack on the threshold cycle wins over the timeout
    memReqM = 1'b1;
    for (int i = 1; i <= 4; i++)
      step($sformatf("ak%0d", i), 4'b1111, 3'b001, FWD_RF, FWD_RF, 1'b0, 1'b0, 1'b0, 1'b0, FWD_RF);
    memAckM = 1'b1;
    step("akThr", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b0, 1'b0, 1'b0, FWD_RF);
    clearIn();
    step("akPost1", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);
    step("akPost2", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);

    // Interlock-only instance versus forwarding instance; x0 never hazards
    regWriteM = 1'b1; rdM = 3; rs1D = 3; rs1E = 3;
    step("ilM", 4'b0000, 3'b000, FWD_M, FWD_RF, 1'b0, 1'b1, 1'b1, 1'b1, FWD_RF);
    clearIn();
    regWriteW = 1'b1; rdW = 4; rs2D = 4;
    step("ilW", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b1, 1'b1, FWD_RF);
    clearIn();
    regWriteE = 1'b1; regWriteM = 1'b1; regWriteW = 1'b1; resultSrcE = RES_LOAD;
    step("x0", 4'b0000, 3'b000, FWD_RF, FWD_RF, 1'b0, 1'b1, 1'b0, 1'b0, FWD_RF);
    clearIn();

    @(negedge clk);
    #1;
    checkVal("qEmpty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
